// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshakes and the data-memory bus used by dmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters and memory.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              p0_req;
    logic              p0_wrt;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_done;
    logic              p0_err;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_wrt;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_done;
    logic              p1_err;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_read;
    logic              mem_wrt;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              busy;

    modport slave (
        input  p0_req, p0_wrt, p0_addr, p0_wdata,
        input  p1_req, p1_wrt, p1_addr, p1_wdata,
        input  mem_data_out,
        output p0_gnt, p0_done, p0_err, p0_rdata,
        output p1_gnt, p1_done, p1_err, p1_rdata,
        output mem_read, mem_wrt, mem_address, mem_data_in, busy
    );

    modport master (
        output p0_req, p0_wrt, p0_addr, p0_wdata,
        output p1_req, p1_wrt, p1_addr, p1_wdata,
        output mem_data_out,
        input  p0_gnt, p0_done, p0_err, p0_rdata,
        input  p1_gnt, p1_done, p1_err, p1_rdata,
        input  mem_read, mem_wrt, mem_address, mem_data_in, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a registered single-port data memory between two requesters.
// One operation per three cycles: grant/strobe, memory sample, capture/done.
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 64
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_DEPTH);

    logic [1:0]        state_reg;
    logic              last_reg;
    logic              port_reg;
    logic              wrt_reg;
    logic              oor_reg;
    logic [1:0]        gnt_reg;
    logic [1:0]        done_reg;
    logic [1:0]        err_reg;
    logic [DATA_W-1:0] rdata_reg [2];
    logic              mem_read_reg;
    logic              mem_wrt_reg;
    logic [ADDR_W-1:0] mem_address_reg;
    logic [DATA_W-1:0] mem_data_in_reg;
    logic              busy_reg;

    logic              win_next;
    logic              wrt_next;
    logic              oor_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;

    // last_reg holds the most recently granted port; it resets to 1 so port 0 wins the first tie.
    always_comb begin
        win_next   = bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
            win_next = ~last_reg;
        end
        wrt_next   = win_next ? bus.p1_wrt   : bus.p0_wrt;
        addr_next  = win_next ? bus.p1_addr  : bus.p0_addr;
        wdata_next = win_next ? bus.p1_wdata : bus.p0_wdata;
        oor_next   = (addr_next >= LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            last_reg        <= 1'b1;
            port_reg        <= 1'b0;
            wrt_reg         <= 1'b0;
            oor_reg         <= 1'b0;
            gnt_reg         <= '0;
            done_reg        <= '0;
            err_reg         <= '0;
            rdata_reg[0]    <= '0;
            rdata_reg[1]    <= '0;
            mem_read_reg    <= 1'b0;
            mem_wrt_reg     <= 1'b0;
            mem_address_reg <= '0;
            mem_data_in_reg <= '0;
            busy_reg        <= 1'b0;
        end else begin
            gnt_reg  <= '0;
            done_reg <= '0;
            err_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (bus.p0_req || bus.p1_req) begin
                        gnt_reg[win_next] <= 1'b1;
                        port_reg          <= win_next;
                        last_reg          <= win_next;
                        wrt_reg           <= wrt_next;
                        oor_reg           <= oor_next;
                        // Out-of-range commands never reach the memory bus at all.
                        if (!oor_next) begin
                            mem_address_reg <= addr_next;
                            mem_data_in_reg <= wdata_next;
                            mem_wrt_reg     <= wrt_next;
                            mem_read_reg    <= ~wrt_next;
                        end
                        busy_reg  <= 1'b1;
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_read_reg <= 1'b0;
                    mem_wrt_reg  <= 1'b0;
                    state_reg    <= CAPTURE;
                end
                CAPTURE: begin
                    done_reg[port_reg] <= 1'b1;
                    err_reg[port_reg]  <= oor_reg;
                    if (!wrt_reg) begin
                        rdata_reg[port_reg] <= oor_reg ? '0 : bus.mem_data_out;
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    mem_read_reg <= 1'b0;
                    mem_wrt_reg  <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign bus.p0_gnt      = gnt_reg[0];
    assign bus.p1_gnt      = gnt_reg[1];
    assign bus.p0_done     = done_reg[0];
    assign bus.p1_done     = done_reg[1];
    assign bus.p0_err      = err_reg[0];
    assign bus.p1_err      = err_reg[1];
    assign bus.p0_rdata    = rdata_reg[0];
    assign bus.p1_rdata    = rdata_reg[1];
    assign bus.mem_read    = mem_read_reg;
    assign bus.mem_wrt     = mem_wrt_reg;
    assign bus.mem_address = mem_address_reg;
    assign bus.mem_data_in = mem_data_in_reg;
    assign bus.busy        = busy_reg;
endmodule
